pulse_train_generator: RTL and testbench
========================================

# pulse_train_generator

Generates a burst of clean, glitch-free rectangular pulses on a single output line: N pulses, each high for H cycles and low for L cycles. Parameters are latched at a start request, with a busy/done handshake. It is the driving end of the edge-based event path. Arpeggiator control logic uses it to produce note-gate and strobe trains, which downstream rising-edge detectors consume as one event per pulse.

## Interface
- CNT_W, 16, width of high/low phase length inputs and internal phase counter
- NUM_W, 8, width of pulse-count input and internal pulse counter
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high; returns block to IDLE
- start  input  1  request a burst; sampled only in IDLE
- high_cycles  input  CNT_W  pulse high time in clk cycles; 0 treated as 1
- low_cycles  input  CNT_W  pulse low time in clk cycles; 0 treated as 1
- num_pulses  input  NUM_W  pulses in burst; 0 = empty burst
- done_clear  input  1  clears sticky done flag
- abort  input  1  terminate burst (present only with PULSE_TRAIN_ABORT_EN)
- pulse  output  1  registered pulse train output
- busy  output  1  high while a burst is in progress
- done  output  1  sticky completion flag

## Operation
- Reset values: pulse=0, busy=0, done=0, state=IDLE, counters=0. Reset overrides all other inputs in the same cycle.
- States: IDLE, HIGH, LOW.
- IDLE:
  - start=1 latches high_cycles, low_cycles and num_pulses into internal registers. Later input changes have no effect on the running burst.
  - Accepting start clears done.
  - num_pulses=0: stay IDLE, busy stays 0, and done=1 next cycle.
  - Otherwise go to HIGH, with pulse=1 and busy=1 next cycle.
- HIGH:
  - pulse=1 for exactly max(H,1) cycles.
  - Then go to LOW and decrement the remaining-pulse counter.
- LOW:
  - pulse=0 for exactly max(L,1) cycles.
  - Then, if remaining pulses are >0, go to HIGH; else go to IDLE with busy=0 and done=1.
  - The trailing low phase is always emitted, so back-to-back bursts remain separated by at least L low cycles.
- start while busy=1 is ignored; no queueing.
- done is sticky. done_clear=1 clears it. If done_clear coincides with a completion set, set wins and done=1.
- Phase counter counts down from the latched length minus 1, full CNT_W width, with no wrap. A length of 2^CNT_W−1 is legal.
- Pulse counter is NUM_W wide; max burst is 2^NUM_W−1 pulses.

## Timing
- Start latency: start high in cycle 0 gives pulse=1 and busy=1 from cycle 1.
- All outputs are registered; no combinational path from any input to any output.
- Burst duration with N>0: N×(H'+L') cycles, where H'=max(H,1) and L'=max(L,1). busy is high for exactly that many cycles.
- done rises in the first cycle busy is 0 after completion.
- Earliest restart: start may be asserted in the cycle done rises. Its first pulse then follows 1 cycle later.
- Reset mid-burst: pulse=0, busy=0, done=0 the next cycle. No completion is reported.

## Configuration
- Macro PULSE_TRAIN_ABORT_EN.
- Defined:
  - The abort port exists.
  - abort=1 in HIGH or LOW forces pulse=0 and state=IDLE next cycle, with busy=0 and done=1.
  - abort in IDLE has no effect.
  - abort has priority over the phase transition in the same cycle.
  - reset has priority over abort.
- Undefined: the abort port and its logic are absent, and bursts always run to completion.

## Test plan
- Nominal burst: H=2, L=3, N=2, start in cycle 0 -> pulse high in cycles 1–2 and 6–7, low in 3–5 and 8–10; busy high in cycles 1–10; done=1 from cycle 11.
- Zero handling: H=0, L=0, N=3 -> three pulses of 1 high / 1 low each; busy high for 6 cycles. Then N=0 -> busy never rises, pulse stays 0, and done=1 one cycle after start.
- Ignored restart: during the nominal burst, assert start with N=5 at cycle 4 -> burst is unchanged (2 pulses, ends cycle 10). Changing high_cycles mid-burst also has no effect.
- Done handshake: assert done_clear in the cycle done would set -> done=1. Assert done_clear one cycle later -> done=0 the following cycle.
- Reset mid-burst: H=4, L=4, N=10, reset at cycle 6 -> pulse=0, busy=0, done=0 from cycle 7. A new start at cycle 8 then produces pulse=1 at cycle 9.
- Abort (PULSE_TRAIN_ABORT_EN): H=3, L=3, N=4, abort in cycle 2 -> pulse=0, busy=0 and done=1 in cycle 3. Build without the macro -> the abort port is absent and the full 24-cycle burst completes.

Source files
------------

// File: rtl/pulse_train_generator.sv
// Burst generator: N rectangular pulses of H high / L low cycles, registered output.
// Optional abort port and logic enabled by defining PULSE_TRAIN_ABORT_EN.
module pulse_train_generator #(
    parameter int CNT_W = 16,
    parameter int NUM_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] high_cycles,
    input  logic [CNT_W-1:0] low_cycles,
    input  logic [NUM_W-1:0] num_pulses,
    input  logic             done_clear,
`ifdef PULSE_TRAIN_ABORT_EN
    input  logic             abort,
`endif
    output logic             pulse,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] hi_m1;
    logic [CNT_W-1:0] lo_m1;
    logic [CNT_W-1:0] cnt;
    logic [NUM_W-1:0] rem;
    logic             abort_req;
    logic             phase_end;
    logic             accept;
    logic             pulse_nxt;
    logic             busy_nxt;
    logic             done_nxt;
    logic             done_set;

    // Zero-length phases behave as one cycle, so store max(x,1)-1.
    function automatic logic [CNT_W-1:0] len_m1(input logic [CNT_W-1:0] x);
        return (x == '0) ? '0 : x - 1'b1;
    endfunction

`ifdef PULSE_TRAIN_ABORT_EN
    assign abort_req = abort && (state != IDLE);
`else
    assign abort_req = 1'b0;
`endif

    assign phase_end = (cnt == '0);
    assign accept    = (state == IDLE) && start;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            pulse <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            pulse <= pulse_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start && num_pulses != '0)
                    state_nxt = HIGH;
            end
            HIGH: begin
                if (abort_req)
                    state_nxt = IDLE;
                else if (phase_end)
                    state_nxt = LOW;
            end
            LOW: begin
                if (abort_req)
                    state_nxt = IDLE;
                else if (phase_end)
                    state_nxt = (rem != '0) ? HIGH : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Completion set takes priority over any clear in the same cycle.
    always_comb begin
        pulse_nxt = (state_nxt == HIGH);
        busy_nxt  = (state_nxt != IDLE);
        done_set  = (accept && num_pulses == '0)
                  || (state == LOW && phase_end && rem == '0)
                  || abort_req;
        done_nxt  = done;
        if (done_set)
            done_nxt = 1'b1;
        else if (done_clear || accept)
            done_nxt = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_m1 <= '0;
            lo_m1 <= '0;
            cnt   <= '0;
            rem   <= '0;
        end else if (abort_req) begin
            cnt <= '0;
            rem <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        hi_m1 <= len_m1(high_cycles);
                        lo_m1 <= len_m1(low_cycles);
                        cnt   <= len_m1(high_cycles);
                        rem   <= num_pulses;
                    end
                end
                HIGH: begin
                    if (phase_end) begin
                        cnt <= lo_m1;
                        rem <= rem - 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                LOW: begin
                    if (!phase_end)
                        cnt <= cnt - 1'b1;
                    else if (rem != '0)
                        cnt <= hi_m1;
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_train_generator.sv
// Scoreboard bench for pulse_train_generator.
// Per-cycle expectations queued, checked by monitor.
module tb_pulse_train_generator;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] high_cycles;
  logic [15:0] low_cycles;
  logic [7:0]  num_pulses;
  logic        done_clear;
`ifdef PULSE_TRAIN_ABORT_EN
  logic        abort;
`endif
  logic        pulse;
  logic        busy;
  logic        done;

  int          checks = 0;
  int          errors = 0;
  logic [2:0]  exp_q[$];
  int          tag_q[$];

  always #5 clk = ~clk;

  pulse_train_generator #(
    .CNT_W(16),
    .NUM_W(8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .high_cycles(high_cycles),
    .low_cycles (low_cycles),
    .num_pulses (num_pulses),
    .done_clear (done_clear),
`ifdef PULSE_TRAIN_ABORT_EN
    .abort      (abort),
`endif
    .pulse      (pulse),
    .busy       (busy),
    .done       (done)
  );

  task automatic run(
    input int id, input int h,
    input int l, input int n,
    input int st_c, input int ex_c,
    input int ex_n, input int dc_a,
    input int dc_b, input int rs_c,
    input int ab_c, input string ep,
    input string eb, input string ed
  );
    for (int i = 0; i < ep.len(); i++) begin
      @(negedge clk);
      start = (i == st_c) || (i == ex_c);
      high_cycles = (i <= st_c) ? 16'(h)
                                : 16'd7;
      low_cycles = 16'(l);
      num_pulses = (i == ex_c) ? 8'(ex_n)
                               : 8'(n);
      done_clear = (i == dc_a) || (i == dc_b);
      reset = (i == rs_c);
`ifdef PULSE_TRAIN_ABORT_EN
      abort = (i == ab_c);
`endif
      exp_q.push_back({ep[i] == "1",
                       eb[i] == "1",
                       ed[i] == "1"});
      tag_q.push_back(id * 1000 + i);
    end
  endtask

  initial begin
    logic [2:0] e;
    int         t;
    forever begin
      @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        if ({pulse, busy, done} !== e) begin
          errors++;
          $display("FAIL run%0d cyc%0d got %b%b%b exp %b",
                   t / 1000, t % 1000,
                   pulse, busy, done, e);
        end
      end
    end
  end

  initial begin
    repeat (2000) @(posedge clk);
    errors++;
    $display("FAIL timeout: wait expired");
    $display("CHECKS %0d ERRORS %0d",
             checks, errors);
    $finish;
  end

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    high_cycles = '0;
    low_cycles  = '0;
    num_pulses  = '0;
    done_clear  = 1'b0;
`ifdef PULSE_TRAIN_ABORT_EN
    abort       = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({pulse, busy, done} !== 3'b000) begin
      errors++;
      $display("FAIL reset state got %b%b%b",
               pulse, busy, done);
    end
    run(0, 0, 0, 0, -1, -1, 0, -1, -1, 0, -1,
        "000", "000", "000");
    run(1, 2, 3, 2, 0, 4, 5, -1, -1, -1, -1,
        "0110001100000",
        "0111111111100",
        "0000000000011");
    run(2, 2, 3, 2, 0, -1, 0, 10, 11, -1, -1,
        "0110001100000",
        "0111111111100",
        "1000000000010");
    run(3, 0, 0, 3, 0, -1, 0, -1, -1, -1, -1,
        "010101000",
        "011111100",
        "000000011");
    run(4, 4, 4, 10, 0, 8, 1, -1, -1, 6, -1,
        "011110000111111100000",
        "011111100111111111110",
        "100000000000000000001");
    run(5, 0, 0, 0, 2, 3, 1, 0, -1, -1, -1,
        "0000111111100",
        "0000111111110",
        "1001000000001");
`ifdef PULSE_TRAIN_ABORT_EN
    run(6, 3, 3, 4, 0, -1, 0, -1, -1, -1, 2,
        "01100", "01100", "10011");
`else
    run(6, 3, 3, 4, 0, -1, 0, -1, -1, -1, 2,
        "011100011100011100011100000",
        "011111111111111111111111100",
        "100000000000000000000000011");
`endif
    @(negedge clk);
    start      = 1'b0;
    done_clear = 1'b0;
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %0d expectations unchecked",
               exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d",
             checks, errors);
    $finish;
  end

endmodule
